// File: rtl/rs232_frame_parser.sv
// rs232_frame_parser
// Assembles HEADER/CMD/LEN/payload/CSUM command frames from the byte stream
// delivered by the UART receiver. Payload bytes are streamed out as they
// arrive. The frame verdict is reported once the checksum byte is seen.
// An inter-byte idle timer aborts frames that stall.
module rs232_frame_parser #(
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 104_166
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [7:0] pay_data,
  output logic       pay_valid,
  output logic [7:0] pay_idx,
  output logic [7:0] cmd_out,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CSUM
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam logic [7:0]  MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [19:0] timer_q, timer_d;

  logic [7:0]  pay_data_q, pay_data_d;
  logic        pay_valid_q, pay_valid_d;
  logic [7:0]  pay_idx_q, pay_idx_d;
  logic [7:0]  cmd_out_q, cmd_out_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;

  // A strobe arriving in the expiry cycle wins, so the timeout needs silence.
  logic timeout_hit;
  logic last_pay;

  assign timeout_hit = (state_q != S_IDLE) && !pi_flag && (timer_q == TIMER_LAST);
  assign last_pay    = (cnt_q == len_q - 8'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: advances only on byte strobes, or falls back to IDLE on timeout.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    state_d = state_q;
    if (pi_flag) begin
      case (state_q)
        S_IDLE:    if (pi_data == HEADER) state_d = S_CMD;
        S_CMD:     state_d = S_LEN;
        S_LEN: begin
          if (pi_data > MAX_LEN_B)  state_d = S_IDLE;
          else if (pi_data == 8'd0) state_d = S_CSUM;
          else                      state_d = S_PAYLOAD;
        end
        S_PAYLOAD: if (last_pay) state_d = S_CSUM;
        S_CSUM:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = S_IDLE;
    end
  end

  // Datapath and output next values: checksum, payload counter, idle timer, pulses.
  always_comb begin
    cmd_d       = cmd_q;
    sum_d       = sum_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q + 20'd1;
    pay_data_d  = pay_data_q;
    pay_idx_d   = pay_idx_q;
    pay_valid_d = 1'b0;
    cmd_out_d   = cmd_out_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    if (pi_flag || state_q == S_IDLE) timer_d = '0;

    if (pi_flag) begin
      case (state_q)
        S_CMD: begin
          cmd_d = pi_data;
          sum_d = pi_data;
        end
        S_LEN: begin
          if (pi_data > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end else begin
            sum_d = sum_q + pi_data;
            len_d = pi_data;
            cnt_d = '0;
          end
        end
        S_PAYLOAD: begin
          pay_data_d  = pi_data;
          pay_idx_d   = cnt_q;
          pay_valid_d = 1'b1;
          sum_d       = sum_q + pi_data;
          cnt_d       = cnt_q + 8'd1;
        end
        S_CSUM: begin
          if (pi_data == sum_q) begin
            frame_ok_d = 1'b1;
            cmd_out_d  = cmd_q;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      timer_d     = '0;
    end
  end

  // Datapath and output registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      sum_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      pay_idx_q   <= '0;
      cmd_out_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      cmd_q       <= cmd_d;
      sum_q       <= sum_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      pay_data_q  <= pay_data_d;
      pay_valid_q <= pay_valid_d;
      pay_idx_q   <= pay_idx_d;
      cmd_out_q   <= cmd_out_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign pay_data  = pay_data_q;
  assign pay_valid = pay_valid_q;
  assign pay_idx   = pay_idx_q;
  assign cmd_out   = cmd_out_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_rs232_frame_parser.sv
// tb_rs232_frame_parser
// Drives byte streams into the parser and compares every output event
// (payload strobe, frame_ok, frame_err) and the cycle it appears in against a
// frame-level reference parser that walks the recorded byte stream.
module tb_rs232_frame_parser;

  localparam logic [7:0] HEADER      = 8'hAA;
  localparam int         MAX_LEN     = 16;
  localparam int         TIMEOUT_CYC = 100;

  localparam logic [1:0] EV_PAY = 2'd0;
  localparam logic [1:0] EV_OK  = 2'd1;
  localparam logic [1:0] EV_ERR = 2'd2;
  localparam logic [1:0] EV_BAD = 2'd3;  // overlapping pulses

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  a;    // payload byte / cmd_out / err_code
    logic [7:0]  b;    // payload index
    logic [31:0] cyc;  // clock edge after which the event is visible
  } ev_t;

  typedef struct {
    logic [7:0] b;
    int         cyc;   // clock edge that samples the byte
  } stim_t;

  typedef logic [7:0] bytes_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pi_data = 8'h00;
  logic       pi_flag = 1'b0;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic [7:0] pay_idx;
  logic [7:0] cmd_out;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  ev_t   obs_q[$];
  ev_t   exp_q[$];
  stim_t stim_q[$];

  rs232_frame_parser #(
    .HEADER     (HEADER),
    .MAX_LEN    (MAX_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pi_data  (pi_data),
    .pi_flag  (pi_flag),
    .pay_data (pay_data),
    .pay_valid(pay_valid),
    .pay_idx  (pay_idx),
    .cmd_out  (cmd_out),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((pay_valid && frame_ok) || (pay_valid && frame_err) || (frame_ok && frame_err))
        obs_q.push_back('{kind: EV_BAD, a: 8'h00, b: 8'h00, cyc: 32'(cyc)});
      else if (pay_valid)
        obs_q.push_back('{kind: EV_PAY, a: pay_data, b: pay_idx, cyc: 32'(cyc)});
      else if (frame_ok)
        obs_q.push_back('{kind: EV_OK, a: cmd_out, b: 8'h00, cyc: 32'(cyc)});
      else if (frame_err)
        obs_q.push_back('{kind: EV_ERR, a: {6'd0, err_code}, b: 8'h00, cyc: 32'(cyc)});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    pi_data = b;
    pi_flag = 1'b1;
    stim_q.push_back('{b: b, cyc: cyc + 1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pi_flag = 1'b0;
    end
  endtask

  task automatic send_seq(input bytes_t s, input int max_gap);
    foreach (s[i]) begin
      send_byte(s[i]);
      idle(int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic start_test();
    idle(2);
    obs_q.delete();
    exp_q.delete();
    stim_q.delete();
  endtask

  // Reference parser: scans the recorded stream frame by frame.
  task automatic build_expected();
    int i;
    int len;
    int sum;
    logic [7:0] cmd;
    exp_q.delete();
    i = 0;
    while (i < stim_q.size()) begin
      if (stim_q[i].b != HEADER) begin
        i++;
        continue;
      end
      if (i + 2 >= stim_q.size()) break;
      cmd = stim_q[i+1].b;
      len = int'(stim_q[i+2].b);
      if (len > MAX_LEN) begin
        exp_q.push_back('{kind: EV_ERR, a: 8'd1, b: 8'd0, cyc: 32'(stim_q[i+2].cyc)});
        i += 3;
        continue;
      end
      if (i + 3 + len >= stim_q.size()) break;
      sum = int'(cmd) + len;
      for (int k = 0; k < len; k++) begin
        exp_q.push_back('{kind: EV_PAY, a: stim_q[i+3+k].b, b: 8'(k),
                          cyc: 32'(stim_q[i+3+k].cyc)});
        sum += int'(stim_q[i+3+k].b);
      end
      if (int'(stim_q[i+3+len].b) == sum % 256)
        exp_q.push_back('{kind: EV_OK, a: cmd, b: 8'd0, cyc: 32'(stim_q[i+3+len].cyc)});
      else
        exp_q.push_back('{kind: EV_ERR, a: 8'd2, b: 8'd0, cyc: 32'(stim_q[i+3+len].cyc)});
      i += 4 + len;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (pay_data  !== 8'h00) begin fails++; $display("FAIL reset pay_data: got %h want 00", pay_data); end
    tests++; if (pay_valid !== 1'b0)  begin fails++; $display("FAIL reset pay_valid: got %b want 0", pay_valid); end
    tests++; if (pay_idx   !== 8'h00) begin fails++; $display("FAIL reset pay_idx: got %h want 00", pay_idx); end
    tests++; if (cmd_out   !== 8'h00) begin fails++; $display("FAIL reset cmd_out: got %h want 00", cmd_out); end
    tests++; if (frame_ok  !== 1'b0)  begin fails++; $display("FAIL reset frame_ok: got %b want 0", frame_ok); end
    tests++; if (frame_err !== 1'b0)  begin fails++; $display("FAIL reset frame_err: got %b want 0", frame_err); end
    tests++; if (err_code  !== 2'd0)  begin fails++; $display("FAIL reset err_code: got %0d want 0", err_code); end
    rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    start_test();
    send_seq('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33}, 2);
    idle(5);
    build_expected();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL good_frame count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL good_frame ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++; if (cmd_out !== 8'h01) begin fails++; $display("FAIL good_frame cmd_out: got %h want 01", cmd_out); end
  endtask

  task automatic test_bad_csum();
    start_test();
    send_seq('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34}, 2);
    idle(5);
    build_expected();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL bad_csum count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL bad_csum ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++; if (cmd_out !== 8'h01) begin fails++; $display("FAIL bad_csum cmd_out kept: got %h want 01", cmd_out); end
    tests++; if (err_code !== 2'd2) begin fails++; $display("FAIL bad_csum err_code held: got %0d want 2", err_code); end
  endtask

  task automatic test_len_error();
    start_test();
    send_seq('{8'hAA, 8'h05, 8'h11}, 2);
    send_seq('{8'h55, 8'hAA, 8'h7F, 8'h00, 8'h7F}, 2);
    idle(5);
    build_expected();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL len_error count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL len_error ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++; if (cmd_out !== 8'h7F) begin fails++; $display("FAIL len_error cmd_out: got %h want 7f", cmd_out); end
    tests++; if (err_code !== 2'd1) begin fails++; $display("FAIL len_error err_code held: got %0d want 1", err_code); end
  endtask

  task automatic test_back_to_back();
    int last_edge;
    start_test();
    send_seq('{8'hAA, 8'h42, 8'h00, 8'h42}, 0);
    last_edge = stim_q[$].cyc;
    idle(5);
    build_expected();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL back_to_back count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL back_to_back ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++;
    if (obs_q.size() == 0 || obs_q[0].kind !== EV_OK || obs_q[0].cyc !== 32'(last_edge)) begin
      fails++; $display("FAIL back_to_back ok_latency: got %0d events want frame_ok at edge %0d", obs_q.size(), last_edge);
    end
  endtask

  task automatic test_timeout();
    int n;
    start_test();
    send_byte(8'hAA);
    idle(1);
    send_byte(8'h01);
    n = stim_q[$].cyc;
    idle(TIMEOUT_CYC + 10);
    exp_q.delete();
    exp_q.push_back('{kind: EV_ERR, a: 8'd3, b: 8'd0, cyc: 32'(n + TIMEOUT_CYC)});
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL timeout count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL timeout ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end

    // Byte arriving exactly in the expiry cycle is processed as LEN.
    start_test();
    send_byte(8'hAA);
    send_byte(8'h01);
    n = stim_q[$].cyc;
    idle(TIMEOUT_CYC - 1);
    send_byte(8'h00);
    tests++; if (stim_q[$].cyc - n != TIMEOUT_CYC) begin fails++; $display("FAIL timeout_edge spacing: got %0d want %0d", stim_q[$].cyc - n, TIMEOUT_CYC); end
    idle(1);
    send_byte(8'h01);
    idle(TIMEOUT_CYC + 10);
    build_expected();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL timeout_edge count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL timeout_edge ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++; if (err_code !== 2'd3) begin fails++; $display("FAIL timeout_edge err_code held: got %0d want 3", err_code); end
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    int len;
    int sum;
    start_test();
    repeat (25) begin
      repeat ($urandom_range(2, 0)) begin
        b = 8'($urandom);
        if (b == HEADER) b = 8'h00;
        send_byte(b); idle(int'($urandom_range(2, 0)));
      end
      send_byte(HEADER); idle(int'($urandom_range(2, 0)));
      b = 8'($urandom);
      sum = int'(b);
      send_byte(b); idle(int'($urandom_range(2, 0)));
      if ($urandom_range(6, 0) == 0) len = int'($urandom_range(MAX_LEN + 6, MAX_LEN + 1));
      else                           len = int'($urandom_range(MAX_LEN, 0));
      sum += len;
      send_byte(8'(len)); idle(int'($urandom_range(2, 0)));
      if (len <= MAX_LEN) begin
        for (int k = 0; k < len; k++) begin
          b = ($urandom_range(7, 0) == 0) ? HEADER : 8'($urandom);
          sum += int'(b);
          send_byte(b); idle(int'($urandom_range(2, 0)));
        end
        b = 8'(sum);
        if ($urandom_range(3, 0) == 0) b = b ^ 8'($urandom_range(255, 1));
        send_byte(b); idle(int'($urandom_range(2, 0)));
      end
    end
    idle(5);
    build_expected();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL random ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    start_test();
    send_seq('{8'hAA, 8'h03, 8'h04, 8'h11, 8'h22}, 0);
    @(negedge clk);
    pi_flag = 1'b0;
    tests++; if (pay_valid !== 1'b1 || pay_data !== 8'h22) begin fails++; $display("FAIL mid_reset pre pay: got %b/%h want 1/22", pay_valid, pay_data); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (pay_valid !== 1'b0)  begin fails++; $display("FAIL mid_reset pay_valid: got %b want 0", pay_valid); end
    tests++; if (pay_data  !== 8'h00) begin fails++; $display("FAIL mid_reset pay_data: got %h want 00", pay_data); end
    tests++; if (pay_idx   !== 8'h00) begin fails++; $display("FAIL mid_reset pay_idx: got %h want 00", pay_idx); end
    tests++; if (cmd_out   !== 8'h00) begin fails++; $display("FAIL mid_reset cmd_out: got %h want 00", cmd_out); end
    tests++; if (frame_ok  !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL mid_reset pulses: got %b%b want 00", frame_ok, frame_err); end
    tests++; if (err_code  !== 2'd0)  begin fails++; $display("FAIL mid_reset err_code: got %0d want 0", err_code); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_test();
    send_seq('{8'h10, 8'h20, 8'hAA, 8'h03, 8'h01, 8'h5A, 8'h5E}, 1);
    idle(5);
    build_expected();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL mid_reset count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL mid_reset ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    tests++; if (cmd_out !== 8'h03) begin fails++; $display("FAIL mid_reset cmd_out: got %h want 03", cmd_out); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_error();
    test_back_to_back();
    test_timeout();
    test_random_frames();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
